// File: rtl/wb_trace_streamer_if.sv
// rtl/wb_trace_streamer_if.sv - byte stream carrying trace frames toward the transmit path
interface wb_trace_streamer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/wb_trace_streamer.sv
// rtl/wb_trace_streamer.sv - frames write-back commits into byte records; WB_TRACE_STAMP_EN adds cycle stamps
module wb_trace_streamer #(
  parameter int NB_DATA    = 32,
  parameter int NB_ADDR    = 5,
  parameter int FIFO_DEPTH = 16,
  parameter int NB_STAMP   = 16
) (
  input  logic                         clk,
  input  logic                         i_rst_n,
  input  logic                         i_trace_en,
  input  logic                         i_halt,
  input  logic                         i_write_enable,
  input  logic [NB_ADDR-1:0]           i_reg2write,
  input  logic [NB_DATA-1:0]           i_write_data,
  wb_trace_streamer_if.master          tx,
  output logic [$clog2(FIFO_DEPTH):0]  o_fifo_count,
  output logic                         o_overflow,
  output logic                         o_idle
);

  localparam int AW = $clog2(FIFO_DEPTH);

`ifdef WB_TRACE_STAMP_EN
  localparam int         FRAME_BYTES = 7;
  localparam logic [2:0] TAG         = 3'b110;
`else
  localparam int         FRAME_BYTES = 5;
  localparam logic [2:0] TAG         = 3'b101;
`endif
  localparam int FRAME_W = FRAME_BYTES * 8;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND} state_t;

  state_t state;
  state_t state_nxt;

  logic [NB_ADDR-1:0] mem_reg  [FIFO_DEPTH];
  logic [NB_DATA-1:0] mem_data [FIFO_DEPTH];
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic [AW:0]        count;
  logic               empty;
  logic               full;
  logic               push_req;
  logic               push;
  logic               pop;
  logic               accept;
  logic               last_byte;
  logic [FRAME_W-1:0] shreg;
  logic [FRAME_W-1:0] frame_nxt;
  logic [2:0]         byte_idx;
  logic [NB_ADDR-1:0] head_reg;
  logic [NB_DATA-1:0] head_data;

  // Pointers carry one extra wrap bit, so with a power-of-two depth the
  // difference is the occupancy and its top bit alone means full.
  assign count     = wr_ptr - rd_ptr;
  assign empty     = (count == '0);
  assign full      = count[AW];

  // Writes to R0 are architectural no-ops, so they never produce a record.
  assign push_req  = i_trace_en & i_write_enable & ~i_halt & (i_reg2write != '0);
  // A full buffer still takes the commit when the serializer frees a slot on the same edge.
  assign push      = push_req & (~full | pop);

  assign accept    = (state == S_SEND) & tx.tx_ready;
  assign last_byte = (byte_idx == 3'(FRAME_BYTES - 1));

  assign head_reg  = mem_reg[rd_ptr[AW-1:0]];
  assign head_data = mem_data[rd_ptr[AW-1:0]];

`ifdef WB_TRACE_STAMP_EN
  logic [NB_STAMP-1:0] stamp_cnt;
  logic [NB_STAMP-1:0] mem_stamp [FIFO_DEPTH];

  // Free-running cycle counter sampled into each captured entry.
  always_ff @(posedge clk) begin
    if (!i_rst_n) stamp_cnt <= '0;
    else          stamp_cnt <= stamp_cnt + NB_STAMP'(1);
  end

  // Stamp storage written alongside the register/data entry.
  always_ff @(posedge clk) begin
    if (i_rst_n && push) mem_stamp[wr_ptr[AW-1:0]] <= stamp_cnt;
  end

  assign frame_nxt = {TAG, 5'(head_reg), 32'(head_data), 16'(mem_stamp[rd_ptr[AW-1:0]])};
`else
  assign frame_nxt = {TAG, 5'(head_reg), 32'(head_data)};
`endif

  // Commit buffer storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (i_rst_n && push) begin
      mem_reg[wr_ptr[AW-1:0]]  <= i_reg2write;
      mem_data[wr_ptr[AW-1:0]] <= i_write_data;
    end
  end

  // Buffer pointers and the sticky drop flag.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      if (push_req && full && !pop) o_overflow <= 1'b1;
    end
  end

  // Serializer state register.
  always_ff @(posedge clk) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Serializer next state and buffer pop. When a frame finishes with more work
  // queued, the next entry is loaded on that same edge and the FSM stays in
  // SEND, so consecutive frames stream without a bubble.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: state_nxt = S_SEND;
      S_SEND: begin
        if (accept && last_byte) begin
          if (!empty) pop = 1'b1;
          else        state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Frame shift register: the presented byte is always the top byte, and it
  // only moves on acceptance, which keeps tx_data stable while stalled.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      shreg    <= '0;
      byte_idx <= '0;
    end else if (pop) begin
      shreg    <= frame_nxt;
      byte_idx <= '0;
    end else if (accept) begin
      shreg    <= shreg << 8;
      byte_idx <= byte_idx + 3'd1;
    end
  end

  assign tx.tx_valid  = (state == S_SEND);
  assign tx.tx_data   = (state == S_SEND) ? shreg[FRAME_W-1 -: 8] : 8'h00;
  assign o_fifo_count = count;
  assign o_idle       = empty & (state == S_IDLE);

endmodule

// File: tb/tb_wb_trace_streamer.sv
// tb/tb_wb_trace_streamer.sv - directed bench with frame-level scoreboard for wb_trace_streamer
module tb_wb_trace_streamer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trace_en = 1'b0;
  logic        halt = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  reg2write = '0;
  logic [31:0] wdata = '0;
  logic [4:0]  fifo_count;
  logic        overflow;
  logic        idle;

  wb_trace_streamer_if tx_if ();

  wb_trace_streamer #(
    .NB_DATA(32), .NB_ADDR(5), .FIFO_DEPTH(16), .NB_STAMP(16)
  ) dut (
    .clk            (clk),
    .i_rst_n        (rst_n),
    .i_trace_en     (trace_en),
    .i_halt         (halt),
    .i_write_enable (we),
    .i_reg2write    (reg2write),
    .i_write_data   (wdata),
    .tx             (tx_if),
    .o_fifo_count   (fifo_count),
    .o_overflow     (overflow),
    .o_idle         (idle)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  exp_q  [$];
  logic [7:0]  seen_q [$];
  logic [15:0] cyc = '0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = '0;

  logic [7:0] lit_t1 [5]  = '{8'hA1, 8'h00, 8'h00, 8'h00, 8'h0F};
  logic [7:0] lit_t2 [10] = '{8'hA2, 8'h00, 8'h00, 8'h00, 8'h16,
                              8'hA3, 8'h00, 8'h00, 8'h00, 8'h16};
  logic [7:0] lit_t3 [5]  = '{8'hA4, 8'h00, 8'h00, 8'h01, 8'h12};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Cycle count since reset, the value a stamped entry must carry.
  always @(posedge clk) begin
    if (!rst_n) cyc <= '0;
    else        cyc <= cyc + 16'd1;
  end

  // Model: a captured commit becomes one frame of bytes appended to the expected stream.
  function automatic void add_frame(input logic [4:0] r, input logic [31:0] d);
`ifdef WB_TRACE_STAMP_EN
    exp_q.push_back({3'b110, r});
`else
    exp_q.push_back({3'b101, r});
`endif
    for (int i = 3; i >= 0; i--) exp_q.push_back(d[8*i +: 8]);
`ifdef WB_TRACE_STAMP_EN
    exp_q.push_back(cyc[15:8]);
    exp_q.push_back(cyc[7:0]);
`endif
  endfunction

  // Drive one commit on the next edge; the model records it if the capture rule holds.
  task automatic commit(input logic [4:0] r, input logic [31:0] d, input bit drop);
    reg2write = r;
    wdata     = d;
    we        = 1'b1;
    if (trace_en && !halt && r != 5'd0 && !drop) add_frame(r, d);
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (!(idle && exp_q.size() == 0) && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    check({name, "_drained"}, 32'(idle && exp_q.size() == 0), 32'd1);
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (!tx_if.tx_valid && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check({name, "_valid_seen"}, 32'(tx_if.tx_valid), 32'd1);
  endtask

  // Compare process: every accepted byte against the model, plus the stall-hold rule.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(tx_if.tx_valid), 32'd1);
        check("hold_data", 32'(tx_if.tx_data), 32'(prev_data));
      end
      check("idle_implies_no_valid", 32'(idle && tx_if.tx_valid), 32'd0);
      if (tx_if.tx_valid && tx_if.tx_ready) begin
        seen_q.push_back(tx_if.tx_data);
        check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("stream_byte", 32'(tx_if.tx_data), 32'(exp_q.pop_front()));
      end
      prev_stall = tx_if.tx_valid && !tx_if.tx_ready;
      prev_data  = tx_if.tx_data;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int run;

    tx_if.tx_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(tx_if.tx_valid), 32'd0);
    check("rst_data", 32'(tx_if.tx_data), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    rst_n    = 1'b1;
    trace_en = 1'b1;
    @(posedge clk); #1;

    // Single commit, latency of two edges to first valid byte.
    tx_if.tx_ready = 1'b1;
    seen_q.delete();
    commit(5'd1, 32'h0000000F, 1'b0);
    lat = 0;
    while (!tx_if.tx_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("t1_latency", 32'(lat), 32'd2);
    wait_drain("t1");
`ifndef WB_TRACE_STAMP_EN
    check("t1_nbytes", 32'(seen_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) check($sformatf("t1_byte%0d", i), 32'(seen_q[i]), 32'(lit_t1[i]));
`endif

    // Back-to-back frames with no gaps.
    seen_q.delete();
    commit(5'd2, 32'd22, 1'b0);
    commit(5'd3, 32'd22, 1'b0);
    wait_valid("t2");
    run = 0;
    while (tx_if.tx_valid && run < 30) begin
      run++;
      @(posedge clk); #1;
    end
`ifndef WB_TRACE_STAMP_EN
    check("t2_valid_run", 32'(run), 32'd10);
`endif
    wait_drain("t2");
`ifndef WB_TRACE_STAMP_EN
    check("t2_nbytes", 32'(seen_q.size()), 32'd10);
    for (int i = 0; i < 10; i++) check($sformatf("t2_byte%0d", i), 32'(seen_q[i]), 32'(lit_t2[i]));
`endif

    // Ready toggling every cycle during a frame.
    seen_q.delete();
    tx_if.tx_ready = 1'b0;
    commit(5'd4, 32'h00000112, 1'b0);
    for (int i = 0; i < 30; i++) begin
      tx_if.tx_ready = (i % 2 == 0);
      @(posedge clk); #1;
    end
    tx_if.tx_ready = 1'b1;
    wait_drain("t3");
`ifndef WB_TRACE_STAMP_EN
    check("t3_nbytes", 32'(seen_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) check($sformatf("t3_byte%0d", i), 32'(seen_q[i]), 32'(lit_t3[i]));
`endif

    // Fill: 17 commits fit (one in the shift register), the 18th is dropped.
    seen_q.delete();
    tx_if.tx_ready = 1'b0;
    check("t4_overflow_before", 32'(overflow), 32'd0);
    for (int i = 1; i <= 17; i++) commit(5'd5, 32'(i), 1'b0);
    check("t4_count_17", 32'(fifo_count), 32'd16);
    check("t4_overflow_17", 32'(overflow), 32'd0);
    commit(5'd5, 32'd18, 1'b1);
    check("t4_count_18", 32'(fifo_count), 32'd16);
    check("t4_overflow_18", 32'(overflow), 32'd1);
    tx_if.tx_ready = 1'b1;
    wait_drain("t4");
`ifndef WB_TRACE_STAMP_EN
    check("t4_nbytes", 32'(seen_q.size()), 32'd85);
`endif
    check("t4_overflow_sticky", 32'(overflow), 32'd1);

    // Ignored commits: R0, halted pipeline, tracing disabled.
    seen_q.delete();
    commit(5'd0, 32'h12345678, 1'b0);
    halt = 1'b1;
    commit(5'd9, 32'h9, 1'b0);
    halt = 1'b0;
    trace_en = 1'b0;
    commit(5'd10, 32'hA, 1'b0);
    trace_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t5_idle%0d", i), 32'(idle), 32'd1);
      check($sformatf("t5_count%0d", i), 32'(fifo_count), 32'd0);
      @(posedge clk); #1;
    end
    check("t5_nbytes", 32'(seen_q.size()), 32'd0);

    // Reset after B2 of a frame with another commit buffered.
    tx_if.tx_ready = 1'b0;
    commit(5'd7, 32'hAABBCCDD, 1'b0);
    commit(5'd8, 32'h01020304, 1'b0);
    wait_valid("t6");
    check("t6_count_before", 32'(fifo_count), 32'd1);
    tx_if.tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tx_if.tx_ready = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    check("t6_valid", 32'(tx_if.tx_valid), 32'd0);
    check("t6_count", 32'(fifo_count), 32'd0);
    check("t6_idle", 32'(idle), 32'd1);
    check("t6_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Recovery after reset.
    tx_if.tx_ready = 1'b1;
    commit(5'd11, 32'hCAFEF00D, 1'b0);
    wait_drain("t7");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
